uart_tx_ctrl: RTL

Transmit-side controller that feeds and paces the UART transmit shift engine (`uart_tx_top`). It owns the transmit holding FIFO, the 16x baud-tick generator and the transmit status/interrupt flags. It sits between the register-file write path (THR, DLL/DLM, FCR, IER) and `uart_tx_top`. It presents `thre`/`din`/`baud_pulse` to the shift engine and consumes its `pop`/`sreg_empty`.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and register-field types used by the TX and RX controllers.
package uart_pkg;

   localparam int unsigned UART_DIV_W    = 16;
   localparam int unsigned TX_FIFO_DEPTH = 16;

   // FCR fields; trig only matters on the receive side.
   typedef struct packed {
      logic       fifo_en;
      logic       rx_clr;
      logic       tx_clr;
      logic [1:0] trig;
   } fcr_t;

   function automatic int unsigned fifo_lvl_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and a combinational head output
// that reads as zero while empty.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_clr,
   input  logic                   i_wr,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_rd,
   output logic [WIDTH-1:0]       o_rdata,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_empty,
   output logic                   o_full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = fifo_lvl_w(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;

   logic w_wr_ok;
   logic w_rd_ok;

   assign o_empty = (r_level == '0);
   assign o_full  = (r_level == LVL_W'(DEPTH));
   assign o_level = r_level;

   // A read frees a slot in the same cycle, so a write into a full FIFO is accepted alongside it.
   assign w_rd_ok = i_rd & ~i_clr & ~o_empty;
   assign w_wr_ok = i_wr & ~i_clr & (~o_full | w_rd_ok);

   assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr_ok) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: holding FIFO, 16x baud-tick generator and THRE status/interrupt,
// feeding the transmit shift engine.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = TX_FIFO_DEPTH,
   parameter int unsigned DIV_W = UART_DIV_W
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_wr_en,
   input  logic [7:0]             i_wr_data,
   input  logic                   i_fifo_en,
   input  logic                   i_fifo_clr,
   input  logic [DIV_W-1:0]       i_divisor,
   input  logic                   i_div_wr,
   input  logic                   i_ier_etbei,
   input  logic                   i_iir_rd,
   input  logic                   i_pop,
   input  logic                   i_sreg_empty,
   output logic                   o_baud_pulse,
   output logic                   o_thre,
   output logic [7:0]             o_din,
   output logic                   o_temt,
   output logic [$clog2(DEPTH):0] o_tx_level,
   output logic                   o_tx_ovf,
   input  logic                   i_clr_ovf,
   output logic                   o_thre_irq
);

   localparam int unsigned LVL_W = fifo_lvl_w(DEPTH);

   logic             r_fifo_en;
   logic             r_ier;
   logic             r_pend;
   logic             r_ovf;
   logic [DIV_W-1:0] r_cnt;
   logic             r_baud;

   logic [LVL_W-1:0] w_level;
   logic             w_empty;
   logic             w_full;
   logic             w_at_cap;
   logic             w_flush;
   logic             w_pop_ok;
   logic             w_wr_ok;
   logic             w_drop;
   logic             w_pend_set;
   logic [DIV_W-1:0] w_cnt_d;
   logic             w_baud_d;

   // Changing the FIFO mode flushes exactly like an FCR clear.
   assign w_flush  = i_fifo_clr | (i_fifo_en != r_fifo_en);
   // In single-register mode the level never exceeds 1, so "not empty" means full.
   assign w_at_cap = i_fifo_en ? w_full : ~w_empty;
   assign w_pop_ok = i_pop & ~w_empty & ~w_flush;
   assign w_wr_ok  = i_wr_en & ~w_flush & (~w_at_cap | w_pop_ok);
   assign w_drop   = i_wr_en & ~w_flush & w_at_cap & ~w_pop_ok;

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (w_flush),
      .i_wr    (w_wr_ok),
      .i_wdata (i_wr_data),
      .i_rd    (w_pop_ok),
      .o_rdata (o_din),
      .o_level (w_level),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign w_pend_set = w_flush
                     | (w_pop_ok & ~w_wr_ok & (w_level == LVL_W'(1)))
                     | (i_ier_etbei & ~r_ier & w_empty);

   always_comb begin
      w_cnt_d  = r_cnt;
      w_baud_d = 1'b0;
      if (i_div_wr) begin
         w_cnt_d = (i_divisor == '0) ? '0 : i_divisor - DIV_W'(1);
      end else if (i_divisor == '0) begin
         w_cnt_d = '0;
      end else if (r_cnt == '0) begin
         w_baud_d = 1'b1;
         w_cnt_d  = i_divisor - DIV_W'(1);
      end else begin
         w_cnt_d = r_cnt - DIV_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fifo_en <= i_fifo_en;
         r_ier     <= 1'b0;
         r_pend    <= 1'b0;
         r_ovf     <= 1'b0;
         r_cnt     <= '0;
         r_baud    <= 1'b0;
      end else begin
         r_fifo_en <= i_fifo_en;
         r_ier     <= i_ier_etbei;
         r_cnt     <= w_cnt_d;
         r_baud    <= w_baud_d;
         if (w_pend_set) r_pend <= 1'b1;
         else if (w_wr_ok || i_iir_rd) r_pend <= 1'b0;
         if (w_drop) r_ovf <= 1'b1;
         else if (i_clr_ovf) r_ovf <= 1'b0;
      end
   end

   assign o_baud_pulse = r_baud;
   assign o_thre       = w_empty;
   assign o_temt       = w_empty & i_sreg_empty;
   assign o_tx_level   = w_level;
   assign o_tx_ovf     = r_ovf;
   assign o_thre_irq   = r_pend & i_ier_etbei;

endmodule
